// File: rtl/router_input_channel_if.sv
// Link and switch handshake bundle for one router input channel.
// The channel uses the slave modport; its neighbours drive the master side.
interface router_input_channel_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  send_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  ready_out;
    logic                  fwd_req;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  fwd_vc;
    logic                  fwd_grant;

    modport master (
        output send_in, data_in, fwd_grant,
        input  ready_out, fwd_req, fwd_data, fwd_vc
    );

    modport slave (
        input  send_in, data_in, fwd_grant,
        output ready_out, fwd_req, fwd_data, fwd_vc
    );
endinterface

// File: rtl/router_input_channel.sv
// Router input port: two polarity-interleaved VC FIFOs between the link
// and the local switch. One VC fills while the other drains each cycle.
module router_input_channel #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_DEPTH   = 2,
    localparam int CNT_W     = $clog2(VC_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   polarity,
    router_input_channel_if.slave  ch,
    output logic [CNT_W-1:0]       vc0_count,
    output logic [CNT_W-1:0]       vc1_count,
    output logic                   overflow_err
);
    localparam int PTR_W = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(VC_DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(VC_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [2][VC_DEPTH];
    logic [PTR_W-1:0]      wr_ptr [2];
    logic [PTR_W-1:0]      rd_ptr [2];
    logic [CNT_W-1:0]      cnt    [2];

    logic wvc;
    logic rvc;
    logic push;
    logic pop;

    // polarity=1: VC0 takes link writes, VC1 feeds the switch
    assign wvc = ~polarity;
    assign rvc = polarity;

    assign ch.ready_out = reset && (cnt[wvc] < FULL);
    assign ch.fwd_req   = reset && (cnt[rvc] != '0);
    assign ch.fwd_vc    = reset && rvc;
    assign ch.fwd_data  = ch.fwd_req ? mem[rvc][rd_ptr[rvc]] : '0;

    assign push = ch.send_in && ch.ready_out;
    assign pop  = ch.fwd_req && ch.fwd_grant;

    assign vc0_count = cnt[0];
    assign vc1_count = cnt[1];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wvc][wr_ptr[wvc]] <= ch.data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr[0]    <= '0;
            wr_ptr[1]    <= '0;
            rd_ptr[0]    <= '0;
            rd_ptr[1]    <= '0;
            cnt[0]       <= '0;
            cnt[1]       <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr[wvc] <= (wr_ptr[wvc] == LAST) ? '0 : wr_ptr[wvc] + PTR_W'(1);
                cnt[wvc]    <= cnt[wvc] + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr[rvc] <= (rd_ptr[rvc] == LAST) ? '0 : rd_ptr[rvc] + PTR_W'(1);
                cnt[rvc]    <= cnt[rvc] - CNT_W'(1);
            end
            if (ch.send_in && !ch.ready_out) begin
                overflow_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_router_input_channel.sv
// Directed bench for router_input_channel.
// Inputs change 1ns after each rising edge; outputs checked after settling.
module tb_router_input_channel;
    localparam int DW    = 64;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          polarity;
    logic [CW-1:0] vc0_count;
    logic [CW-1:0] vc1_count;
    logic          overflow_err;

    int total = 0;
    int bad   = 0;

    router_input_channel_if #(.DATA_WIDTH(DW)) ch ();

    router_input_channel #(
        .DATA_WIDTH(DW),
        .VC_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .polarity    (polarity),
        .ch          (ch.slave),
        .vc0_count   (vc0_count),
        .vc1_count   (vc1_count),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pol, input logic snd,
                         input logic [DW-1:0] d, input logic gnt);
        polarity     = pol;
        ch.send_in   = snd;
        ch.data_in   = d;
        ch.fwd_grant = gnt;
        #1;
    endtask

    initial begin
        // 1: reset while the link is sending
        reset = 1'b0;
        drive(1'b1, 1'b1, 64'hA5, 1'b0);
        cyc();
        cyc();
        chk("rst_ready", 64'(ch.ready_out), 64'd0);
        chk("rst_req", 64'(ch.fwd_req), 64'd0);
        chk("rst_vc0", 64'(vc0_count), 64'd0);
        chk("rst_vc1", 64'(vc1_count), 64'd0);
        chk("rst_ovf", 64'(overflow_err), 64'd0);
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rel_ready", 64'(ch.ready_out), 64'd1);

        // 2: single flit through VC0
        drive(1'b1, 1'b1, 64'h11, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t2_req", 64'(ch.fwd_req), 64'd1);
        chk("t2_vc", 64'(ch.fwd_vc), 64'd0);
        chk("t2_data", ch.fwd_data, 64'h11);
        chk("t2_cnt", 64'(vc0_count), 64'd1);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        cyc();
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        chk("t2_cnt0", 64'(vc0_count), 64'd0);
        chk("t2_req0", 64'(ch.fwd_req), 64'd0);
        chk("t2_vc1", 64'(ch.fwd_vc), 64'd1);

        // 3: an all-zero flit is real data
        drive(1'b1, 1'b1, 64'h0, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t3_cnt", 64'(vc0_count), 64'd1);
        chk("t3_req", 64'(ch.fwd_req), 64'd1);
        chk("t3_data", ch.fwd_data, 64'h0);
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        cyc();

        // 4: fill VC0, overflow, drain in order
        drive(1'b1, 1'b1, 64'h1, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        cyc();
        drive(1'b1, 1'b1, 64'h2, 1'b0);
        chk("t4_ready1", 64'(ch.ready_out), 64'd1);
        cyc();
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        cyc();
        drive(1'b1, 1'b1, 64'h3, 1'b0);
        chk("t4_full_rdy", 64'(ch.ready_out), 64'd0);
        chk("t4_full_cnt", 64'(vc0_count), 64'd2);
        cyc();
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t4_ovf", 64'(overflow_err), 64'd1);
        chk("t4_cnt", 64'(vc0_count), 64'd2);
        chk("t4_head1", ch.fwd_data, 64'h1);
        cyc();
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        chk("t4_cnt1", 64'(vc0_count), 64'd1);
        cyc();
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        chk("t4_head2", ch.fwd_data, 64'h2);
        cyc();
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        chk("t4_empty", 64'(vc0_count), 64'd0);
        chk("t4_ready", 64'(ch.ready_out), 64'd1);
        chk("t4_ovf_sticky", 64'(overflow_err), 64'd1);

        // 5: interleave VC0 and VC1 with grant held high
        drive(1'b1, 1'b1, 64'hA, 1'b1);
        cyc();
        drive(1'b0, 1'b1, 64'hB, 1'b1);
        chk("t5_dA", ch.fwd_data, 64'hA);
        chk("t5_vA", 64'(ch.fwd_vc), 64'd0);
        cyc();
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        chk("t5_dB", ch.fwd_data, 64'hB);
        chk("t5_vB", 64'(ch.fwd_vc), 64'd1);
        chk("t5_rB", 64'(ch.fwd_req), 64'd1);
        cyc();
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        chk("t5_vc0", 64'(vc0_count), 64'd0);
        chk("t5_vc1", 64'(vc1_count), 64'd0);

        // 6: asynchronous reset with a flit parked in VC1
        drive(1'b0, 1'b1, 64'hC, 1'b0);
        cyc();
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        chk("t6_vc1", 64'(vc1_count), 64'd1);
        chk("t6_req", 64'(ch.fwd_req), 64'd1);
        chk("t6_data", ch.fwd_data, 64'hC);
        reset = 1'b0;
        #1;
        chk("t6_a_req", 64'(ch.fwd_req), 64'd0);
        chk("t6_a_data", ch.fwd_data, 64'h0);
        chk("t6_a_vc", 64'(ch.fwd_vc), 64'd0);
        chk("t6_a_vc1", 64'(vc1_count), 64'd0);
        chk("t6_a_rdy", 64'(ch.ready_out), 64'd0);
        chk("t6_a_ovf", 64'(overflow_err), 64'd0);
        cyc();
        reset = 1'b1;
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        chk("t6_r_req", 64'(ch.fwd_req), 64'd0);
        chk("t6_r_data", ch.fwd_data, 64'h0);
        cyc();
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        cyc();
        drive(1'b1, 1'b0, 64'h0, 1'b0);
        chk("t6_gone", 64'(ch.fwd_req), 64'd0);
        chk("t6_gone_cnt", 64'(vc1_count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/router_input_channel.md
Name: router_input_channel

Overview:
Receive side of the router-to-router link. It sits at each router input port, facing the upstream neighbour's output channel across the link.
- Accepts send/data flits from the link and buffers them in two polarity-interleaved virtual channels (VC0 even, VC1 odd).
- Returns ready to the upstream transmitter.
- Presents buffered flits to the local switch with a req/grant handshake.

Parameters:
DATA_WIDTH, 64, flit width in bits.
VC_DEPTH, 2, entries per virtual channel FIFO; any integer >= 1.
CNT_W, $clog2(VC_DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; asserted when 0.
polarity  input  1  network phase; 1 = even cycle, 0 = odd cycle; toggles every cycle.
send_in  input  1  upstream output channel is driving a valid flit this cycle.
data_in  input  DATA_WIDTH  flit from the link.
ready_out  output  1  this channel can accept a flit into the link-facing VC this cycle.
fwd_req  output  1  a flit is available to the switch.
fwd_data  output  DATA_WIDTH  head flit of the switch-facing VC.
fwd_vc  output  1  index of the VC driving fwd_data (0 = VC0, 1 = VC1).
fwd_grant  input  1  switch accepts fwd_data this cycle.
vc0_count  output  CNT_W  VC0 occupancy.
vc1_count  output  CNT_W  VC1 occupancy.
overflow_err  output  1  sticky error flag: a flit arrived while not ready.

Behaviour:
- Phase mapping:
  - polarity=1: VC0 is link-facing (write) and VC1 is switch-facing (read).
  - polarity=0: VC1 is link-facing and VC0 is switch-facing.
  - A VC is never pushed and popped in the same cycle.
- Storage:
  - Each VC is a circular FIFO of VC_DEPTH entries with wr_ptr, rd_ptr and a count register.
  - Pointers wrap from VC_DEPTH-1 to 0.
  - Occupancy is tracked only by count. An all-zero flit is legal data and is stored and forwarded like any other flit.
- ready_out: combinational = reset deasserted && (count of the link-facing VC < VC_DEPTH).
- Write: on the rising edge, if send_in && ready_out, data_in is stored at the link-facing VC's wr_ptr; wr_ptr and count increment.
- Overflow: on the rising edge, if send_in && !ready_out, the flit is dropped, no state changes, and overflow_err is set to 1. overflow_err clears only on reset.
- Read outputs (combinational from registered state):
  - fwd_req = count of the switch-facing VC != 0.
  - fwd_vc = switch-facing VC index.
  - fwd_data = that VC's head entry when fwd_req=1, else all zeros.
- Pop: on the rising edge, if fwd_req && fwd_grant, rd_ptr of the switch-facing VC increments and count decrements. fwd_grant without fwd_req is ignored.
- Latency: a flit written in cycle N becomes visible on fwd_* in the next cycle whose polarity makes its VC switch-facing. With alternating polarity that is cycle N+1 at the earliest.
- Ordering: strict FIFO within each VC. There is no ordering guarantee between VCs.
- Full boundary: with count==VC_DEPTH, ready_out stays low in that VC's write phase. It returns high in the next write phase after at least one pop.
- Empty boundary: with count==0, fwd_req=0 and fwd_data=0.
- Reset: asynchronous assertion immediately clears pointers, counts and overflow_err, and forces ready_out=0, fwd_req=0, fwd_data=0, fwd_vc=0 and both counts to 0. Flits in flight are discarded. Normal operation resumes on the first rising edge after deassertion.
- Polarity held constant (protocol misuse): behaviour stays well-defined; one VC only fills and the other only drains.

Test Plan:
1. Reset with send_in=1 and data_in=64'hA5: ready_out=0, fwd_req=0, counts 0, overflow_err=0. After release with polarity=1, ready_out=1.
2. polarity alternates starting at 1; send 64'h11 at the polarity=1 edge → next cycle (polarity=0) fwd_req=1, fwd_vc=0, fwd_data=64'h11, vc0_count=1. Grant → vc0_count=0 and fwd_req=0 afterwards.
3. Send 64'h0 at polarity=1 → vc0_count=1 and the flit is forwarded as fwd_data=0 with fwd_req=1, so zero is not treated as empty.
4. VC_DEPTH=2, no grants: send 64'h1 and 64'h2 into VC0 in consecutive VC0 write phases → ready_out=0 in the next polarity=1 cycle. Sending 64'h3 there sets overflow_err=1 and leaves vc0_count=2. Two grants then yield 64'h1 followed by 64'h2, and ready_out returns to 1.
5. Interleave: VC0 receives 64'hA, then VC1 receives 64'hB, with grant held high → fwd_data sequence is A (fwd_vc=0) then B (fwd_vc=1), and both counts return to 0.
6. Drop reset to 0 mid-stream with vc1_count=1 → all outputs clear asynchronously before the next clock edge, and the stored flit is never forwarded.
